// File: rtl/aes_ctr_pkg.sv
// Shared constants, state encoding and counter-block layout for the AES-CTR core.
package aes_ctr_pkg;

    localparam int BLOCK_W = 128;
    localparam int CTR_W   = 32;
    localparam int NONCE_W = BLOCK_W - CTR_W;

    localparam int AES128_KEY_LEN = 128;
    localparam int AES128_ROUNDS  = 10;
    localparam int AES128_NK      = 4;
    localparam int AES192_KEY_LEN = 192;
    localparam int AES192_ROUNDS  = 12;
    localparam int AES192_NK      = 6;
    localparam int AES256_KEY_LEN = 256;
    localparam int AES256_ROUNDS  = 14;
    localparam int AES256_NK      = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    typedef struct packed {
        logic [NONCE_W-1:0] nonce;
        logic [CTR_W-1:0]   ctr;
    } ctr_blk_t;

endpackage

// File: rtl/aes_ctr_core_engine.sv
// AES forward cipher for one block, purely combinational, with the key schedule expanded inline.
module AESEngine
    import aes_ctr_pkg::*;
#(
    parameter int KEY_LEN = AES128_KEY_LEN,
    parameter int ROUNDS  = AES128_ROUNDS,
    parameter int NK      = AES128_NK
) (
    input  logic [BLOCK_W-1:0] blk_in,
    input  logic [KEY_LEN-1:0] key,
    output logic [BLOCK_W-1:0] blk_out
);
    localparam int NW = 4 * (ROUNDS + 1);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254) followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] inv;
        r = x;
        for (int i = 0; i < 6; i++) r = gmul(gmul(r, r), x);
        inv = gmul(r, r);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    function automatic logic [BLOCK_W-1:0] sub_bytes(input logic [BLOCK_W-1:0] s);
        logic [BLOCK_W-1:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
        return o;
    endfunction

    // Byte (row r, column c) lives at bits 8*(15-(r+4c)) +: 8.
    function automatic logic [BLOCK_W-1:0] shift_rows(input logic [BLOCK_W-1:0] s);
        logic [BLOCK_W-1:0] o;
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[8*(15-(r+4*c)) +: 8] = s[8*(15-(r+4*((c+r)%4))) +: 8];
        return o;
    endfunction

    function automatic logic [BLOCK_W-1:0] mix_columns(input logic [BLOCK_W-1:0] s);
        logic [BLOCK_W-1:0] o;
        logic [3:0][7:0]    a;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = s[8*(15-(k+4*c)) +: 8];
            for (int k = 0; k < 4; k++)
                o[8*(15-(k+4*c)) +: 8] = xtime(a[k]) ^ xtime(a[(k+1)%4]) ^ a[(k+1)%4]
                                       ^ a[(k+2)%4] ^ a[(k+3)%4];
        end
        return o;
    endfunction

    logic [NW-1:0][31:0] w;
    logic [BLOCK_W-1:0]  st;
    logic [31:0]         tmp;
    logic [7:0]          rcon;

    always_comb begin
        w    = '0;
        st   = '0;
        tmp  = '0;
        rcon = 8'h01;
        for (int i = 0; i < NK; i++) w[i] = key[KEY_LEN-1-32*i -: 32];
        for (int i = NK; i < NW; i++) begin
            tmp = w[i-1];
            if (i % NK == 0) begin
                tmp  = sub_word({tmp[23:0], tmp[31:24]}) ^ {rcon, 24'h000000};
                rcon = xtime(rcon);
            end else if (NK > 6 && i % NK == 4) begin
                tmp = sub_word(tmp);
            end
            w[i] = w[i-NK] ^ tmp;
        end
        st = blk_in ^ {w[0], w[1], w[2], w[3]};
        for (int r = 1; r <= ROUNDS; r++) begin
            st = shift_rows(sub_bytes(st));
            if (r != ROUNDS) st = mix_columns(st);
            st = st ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
        blk_out = st;
    end

endmodule

// File: rtl/aes_ctr_core.sv
// AES-CTR stream core: each accepted 128-bit beat is XORed with AES(key, counter); enc == dec.
// Latency: 1 cycle from the accepting edge to out_valid.
// Backpressure: in_ready drops while a result is held with out_ready low; the counter does not advance.
module aes_ctr_core
    import aes_ctr_pkg::*;
#(
    parameter int KEY_LEN = AES128_KEY_LEN,
    parameter int ROUNDS  = AES128_ROUNDS,
    parameter int NK      = AES128_NK
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [KEY_LEN-1:0] key,
    input  logic [BLOCK_W-1:0] iv,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_data,
    output logic               out_last,
    output logic               busy,
    output logic               ctr_wrap
);
    state_t             state_q, state_d;
    logic [KEY_LEN-1:0] key_q, key_d;
    ctr_blk_t           ctr_q, ctr_d;
    logic               out_valid_q, out_valid_d;
    logic [BLOCK_W-1:0] out_data_q, out_data_d;
    logic               out_last_q, out_last_d;
    logic               ctr_wrap_q, ctr_wrap_d;
    logic [BLOCK_W-1:0] keystream;
    logic               accept;

    AESEngine #(.KEY_LEN(KEY_LEN), .ROUNDS(ROUNDS), .NK(NK)) u_aes (
        .blk_in  (ctr_q),
        .key     (key_q),
        .blk_out (keystream)
    );

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        ctr_d       = ctr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        ctr_wrap_d  = ctr_wrap_q;
        in_ready    = (state_q == ACTIVE) && !load && (!out_valid_q || out_ready);
        accept      = in_valid && in_ready;

        // A load restarts the stream and drops any result still waiting.
        if (load) begin
            state_d     = ACTIVE;
            key_d       = key;
            ctr_d       = iv;
            ctr_wrap_d  = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            if (out_valid_q && out_ready) out_valid_d = 1'b0;
            if (accept) begin
                out_valid_d = 1'b1;
                out_data_d  = in_data ^ keystream;
                out_last_d  = in_last;
                ctr_d.ctr   = ctr_q.ctr + CTR_W'(1);
                if (&ctr_q.ctr) ctr_wrap_d = 1'b1;
                if (in_last) state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            key_q       <= '0;
            ctr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            ctr_wrap_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            ctr_q       <= ctr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            ctr_wrap_q  <= ctr_wrap_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q == ACTIVE);
    assign ctr_wrap  = ctr_wrap_q;

endmodule
